pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the five-stage MIPS core; the successor to the fixed-field, enable-only inter-stage registers (F/D, D/E, E/M, M/W). It carries PC, instruction, a packed operand payload and a delay-slot flag between two stages. It adds a valid/ready handshake, flush-to-bubble, and an optional two-entry skid buffer so multi-cycle units (MDU, bus waits) can stall without a combinational ready path back through the pipeline. One instance replaces each hand-written stage register.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/pipe_entry_reg.sv | 32 +++
 rtl/pipe_stage_reg.sv | 110 +++++++++++
 tb/tb_pipe_stage_reg.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the five-stage MIPS core pipeline.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // Control/identity fields of one pipeline entry; payload width stays a parameter.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
    } stage_entry_t;

    // Bubble that keeps the supplied PC (EPC source for a later exception stage).
    function automatic stage_entry_t bubble_of(input logic [31:0] pc);
        stage_entry_t e;
        e.valid = 1'b0;
        e.pc    = pc;
        e.instr = NOP_INSTR;
        e.bd    = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Single pipeline entry register: load, clear-to-bubble (PC kept), synchronous reset.
module pipe_entry_reg
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = 96,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  stage_entry_t      d_entry,
    input  logic [DATA_W-1:0] d_data,
    output stage_entry_t      q_entry,
    output logic [DATA_W-1:0] q_data
);

    // Clear wins over load so a flush can never be overridden by a same-cycle load.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_entry <= bubble_of(RESET_PC);
            q_data  <= '0;
        end else if (clear) begin
            q_entry <= bubble_of(q_entry.pc);
            q_data  <= '0;
        end else if (load) begin
            q_entry <= d_entry;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register with valid/ready handshake, flush and optional skid entry.
module pipe_stage_reg
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = 96,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter bit          SKID     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_bd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bd,
    output logic [1:0]        occupancy
);

    stage_entry_t      in_entry, m_q, s_q, m_d;
    logic [DATA_W-1:0] m_data_q, s_data_q, m_data_d;
    logic              m_load, m_clear, s_load, s_clear, m_src_s;
    logic              en_q, m_free, accept;

    assign in_entry = '{valid: 1'b1, pc: in_pc, instr: in_instr, bd: in_bd};

    // Holds in_ready low during reset and for the cycle it is released.
    always_ff @(posedge clk) begin
        if (reset) en_q <= 1'b0;
        else       en_q <= 1'b1;
    end

    assign m_free   = !m_q.valid || out_ready;
    assign in_ready = SKID ? (en_q && !s_q.valid) : (en_q && m_free);
    assign accept   = in_valid && in_ready && !flush;

    // Steering of both entries; S always drains into M before new input does.
    always_comb begin
        m_load  = 1'b0;
        m_clear = 1'b0;
        s_load  = 1'b0;
        s_clear = 1'b0;
        m_src_s = 1'b0;
        if (flush) begin
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else if (m_free) begin
            if (s_q.valid) begin
                m_load  = 1'b1;
                m_src_s = 1'b1;
                if (accept) s_load  = 1'b1;
                else        s_clear = 1'b1;
            end else if (accept) begin
                m_load = 1'b1;
            end else begin
                m_clear = 1'b1;
            end
        end else if (accept) begin
            s_load = 1'b1;
        end
    end

    assign m_d      = m_src_s ? s_q      : in_entry;
    assign m_data_d = m_src_s ? s_data_q : in_data;

    pipe_entry_reg #(.DATA_W(DATA_W), .RESET_PC(RESET_PC)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (m_load),
        .clear   (m_clear),
        .d_entry (m_d),
        .d_data  (m_data_d),
        .q_entry (m_q),
        .q_data  (m_data_q)
    );

    // Skid entry exists only in the registered-ready configuration.
    if (SKID) begin : g_skid
        pipe_entry_reg #(.DATA_W(DATA_W), .RESET_PC(RESET_PC)) u_skid (
            .clk     (clk),
            .reset   (reset),
            .load    (s_load),
            .clear   (s_clear),
            .d_entry (in_entry),
            .d_data  (in_data),
            .q_entry (s_q),
            .q_data  (s_data_q)
        );
    end else begin : g_no_skid
        logic unused_skid_ctrl;
        assign unused_skid_ctrl = s_load | s_clear;
        assign s_q      = bubble_of(RESET_PC);
        assign s_data_q = '0;
    end

    assign out_valid = m_q.valid;
    assign out_pc    = m_q.pc;
    assign out_instr = m_q.instr;
    assign out_bd    = m_q.bd;
    assign out_data  = m_data_q;
    assign occupancy = 2'(m_q.valid) + 2'(s_q.valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg, SKID=1 and SKID=0 instances driven in parallel.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 96;

    logic              clk = 1'b0;
    logic              reset, in_valid, in_bd, flush, out_ready;
    logic [31:0]       in_pc, in_instr;
    logic [DATA_W-1:0] in_data;

    logic              in_ready1, out_valid1, out_bd1;
    logic [31:0]       out_pc1, out_instr1;
    logic [DATA_W-1:0] out_data1;
    logic [1:0]        occ1;

    logic              in_ready0, out_valid0, out_bd0;
    logic [31:0]       out_pc0, out_instr0;
    logic [DATA_W-1:0] out_data0;
    logic [1:0]        occ0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W), .RESET_PC(32'h0000_3000), .SKID(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data), .in_bd(in_bd),
        .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
        .out_pc(out_pc1), .out_instr(out_instr1), .out_data(out_data1),
        .out_bd(out_bd1), .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .RESET_PC(32'h0000_3000), .SKID(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data), .in_bd(in_bd),
        .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
        .out_pc(out_pc0), .out_instr(out_instr0), .out_data(out_data0),
        .out_bd(out_bd0), .occupancy(occ0)
    );

    // Single comparison point for every check.
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample #1 after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an entry whose instr/data/bd are derived from its pc.
    task automatic offer(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = 32'h2000_0000 | pc;
        in_data  = {32'hDEAD_0000 | pc, 32'h0, pc};
        in_bd    = pc[2];
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        offer(32'h3004);
        tick(); tick();
        check("rst_out_pc",    128'(out_pc1),    128'h3000);
        check("rst_out_valid", 128'(out_valid1), 128'h0);
        check("rst_out_instr", 128'(out_instr1), 128'h0);
        check("rst_out_data",  128'(out_data1),  128'h0);
        check("rst_in_ready1", 128'(in_ready1),  128'h0);
        check("rst_in_ready0", 128'(in_ready0),  128'h0);
        check("rst_occ",       128'(occ1),       128'h0);

        reset = 1'b0; in_valid = 1'b0;
        tick();
        check("post_rst_ready1", 128'(in_ready1), 128'h1);
        check("post_rst_ready0", 128'(in_ready0), 128'h1);

        // Streaming with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(32'h3000 + 32'(4 * i));
            check("stream_in_ready", 128'(in_ready1), 128'h1);
            tick();
            check("stream_pc",    128'(out_pc1),    128'(32'h3000 + 32'(4 * i)));
            check("stream_instr", 128'(out_instr1), 128'(32'h2000_3000 + 32'(4 * i)));
            check("stream_valid", 128'(out_valid1), 128'h1);
            check("stream_occ",   128'(occ1),       128'h1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_valid", 128'(out_valid1), 128'h0);
        check("stream_drain_pc",    128'(out_pc1),    128'h3008);

        // Backpressure fills M then S, third entry held upstream.
        out_ready = 1'b0;
        offer(32'h3000);
        tick();
        offer(32'h3004);
        check("bp_ready_s_empty", 128'(in_ready1), 128'h1);
        tick();
        offer(32'h3008);
        check("bp_ready_full", 128'(in_ready1), 128'h0);
        check("bp_occ2",       128'(occ1),      128'h2);
        tick();
        check("bp_hold_pc",  128'(out_pc1), 128'h3000);
        check("bp_hold_occ", 128'(occ1),    128'h2);
        out_ready = 1'b1;
        tick();
        check("bp_out2_pc",    128'(out_pc1),   128'h3004);
        check("bp_out2_data",  128'(out_data1), 128'({32'hDEAD_3004, 32'h0, 32'h3004}));
        check("bp_out2_bd",    128'(out_bd1),   128'h1);
        check("bp_ready_back", 128'(in_ready1), 128'h1);
        tick();
        check("bp_out3_pc",    128'(out_pc1),    128'h3008);
        check("bp_out3_valid", 128'(out_valid1), 128'h1);
        in_valid = 1'b0;
        tick();
        check("bp_empty_occ", 128'(occ1), 128'h0);

        // Flush with both entries held and a new entry offered.
        out_ready = 1'b0;
        offer(32'h3020); tick();
        offer(32'h3024); tick();
        check("fl_pre_occ", 128'(occ1), 128'h2);
        offer(32'h3028);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 128'(out_valid1), 128'h0);
        check("fl_instr", 128'(out_instr1), 128'h0);
        check("fl_data",  128'(out_data1),  128'h0);
        check("fl_pc",    128'(out_pc1),    128'h3020);
        check("fl_occ",   128'(occ1),       128'h0);
        check("fl_occ0",  128'(occ0),       128'h0);
        tick();
        check("fl_not_captured", 128'(occ1), 128'h0);
        check("fl_ready",        128'(in_ready1), 128'h1);

        // SKID=0 stall: combinational ready follows out_ready.
        offer(32'h3030);
        tick();
        check("s0_out_pc",  128'(out_pc0),   128'h3030);
        check("s0_stall",   128'(in_ready0), 128'h0);
        offer(32'h3034);
        out_ready = 1'b1;
        #1;
        check("s0_ready_comb", 128'(in_ready0), 128'h1);
        tick();
        check("s0_repl_pc",    128'(out_pc0),    128'h3034);
        check("s0_repl_valid", 128'(out_valid0), 128'h1);
        check("s0_occ",        128'(occ0),       128'h1);

        // Bubble keeps the last PC.
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        offer(32'h3010);
        in_bd = 1'b1;
        tick();
        check("bub_load_pc", 128'(out_pc1), 128'h3010);
        check("bub_load_bd", 128'(out_bd1), 128'h1);
        in_valid = 1'b0;
        tick();
        check("bub_valid",  128'(out_valid1), 128'h0);
        check("bub_instr",  128'(out_instr1), 128'h0);
        check("bub_bd",     128'(out_bd1),    128'h0);
        check("bub_data",   128'(out_data1),  128'h0);
        check("bub_pc",     128'(out_pc1),    128'h3010);
        check("bub_pc0",    128'(out_pc0),    128'h3010);
        check("bub_valid0", 128'(out_valid0), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
